stack_controller: RTL

Sequencing controller for the return-address stack memory of the MIPS core. It accepts push requests (JAL) and pop requests (JS) from decode, drives a synchronous single-port stack RAM, and tracks the top-of-stack pointer and occupancy. It returns the popped address to the PC-select logic with a valid pulse, and holds decode off with `busy` while an access is in flight.

---
 rtl/stack_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/stack_controller.sv
// Return-address stack sequencer: push/pop requests drive a 1-cycle-latency stack RAM.
// Optional overflow/underflow trap: define STACK_CTRL_OVF_TRAP_EN (otherwise the stack is circular).
module stack_controller #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          JAL_signal,
  input  logic          JS_signal,
  input  logic [DW-1:0] PC_plus4,
  output logic          busy,
  output logic          ret_valid,
  output logic [DW-1:0] ret_addr,
  output logic [AW-1:0] Top_Stack,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          overflow,
  output logic          underflow,
  output logic          trap
);

  typedef enum logic [2:0] {IDLE, PUSH_WR, POP_RD, POP_WAIT, ERROR} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state, next_state;
  logic [AW-1:0] tp;
  logic          push_req, pop_req, ovf_evt, unf_evt;

  assign busy      = (state != IDLE);
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign Top_Stack = tp;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Push wins over a simultaneous pop; the pop request is simply dropped.
  always_comb begin
    next_state = state;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (JAL_signal) begin
          if (!full) begin
            push_req   = 1'b1;
            next_state = PUSH_WR;
          end else begin
            ovf_evt = 1'b1;
`ifdef STACK_CTRL_OVF_TRAP_EN
            next_state = ERROR;
`else
            push_req   = 1'b1;
            next_state = PUSH_WR;
`endif
          end
        end else if (JS_signal) begin
          if (!empty) begin
            pop_req    = 1'b1;
            next_state = POP_RD;
          end else begin
            unf_evt = 1'b1;
`ifdef STACK_CTRL_OVF_TRAP_EN
            next_state = ERROR;
`endif
          end
        end
      end
      PUSH_WR:  next_state = IDLE;
      POP_RD:   next_state = POP_WAIT;
      POP_WAIT: next_state = IDLE;
      ERROR:    next_state = ERROR;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp        <= '0;
      count     <= '0;
      ret_addr  <= '0;
      ret_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      ret_valid <= 1'b0;
      overflow  <= ovf_evt;
      underflow <= unf_evt;
      if (push_req) begin
        mem_wdata <= PC_plus4;
        mem_addr  <= tp;
        mem_we    <= 1'b1;
      end
      if (pop_req) begin
        mem_addr <= tp - AW'(1);
        mem_re   <= 1'b1;
      end
      // An overflowing circular push advances tp but leaves count saturated.
      if (state == PUSH_WR) begin
        tp <= tp + AW'(1);
        if (!full) count <= count + (AW+1)'(1);
      end
      if (state == POP_RD) begin
        tp    <= tp - AW'(1);
        count <= count - (AW+1)'(1);
      end
      if (state == POP_WAIT) begin
        ret_addr  <= mem_rdata;
        ret_valid <= 1'b1;
      end
`ifndef STACK_CTRL_OVF_TRAP_EN
      if (unf_evt) begin
        ret_addr  <= '0;
        ret_valid <= 1'b1;
      end
`endif
    end
  end

`ifdef STACK_CTRL_OVF_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                 trap <= 1'b0;
    else if (ovf_evt || unf_evt) trap <= 1'b1;
  end
`else
  assign trap = 1'b0;
`endif

endmodule
